// File: rtl/pc_seq_pkg.sv
// Shared opcode constants and FSM state encoding for the program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_JMP  = 4'd1;
    localparam logic [3:0] OP_BRZ  = 4'd2;
    localparam logic [3:0] OP_CALL = 4'd3;
    localparam logic [3:0] OP_RET  = 4'd4;
    localparam logic [3:0] OP_HALT = 4'd5;

endpackage

// File: rtl/pc_return_stack.sv
// LIFO of return addresses; push/pop are ignored when full/empty, and reset empties it.
module pc_return_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top_data,
    output logic         full,
    output logic         empty
);
    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SP_W-1:0]           sp_q, sp_d;
    logic [DEPTH-1:0][W-1:0]   mem_q, mem_d;
    logic [IDX_W-1:0]          wr_idx, rd_idx;

    // sp counts entries, so the next free slot is sp and the top is sp-1
    assign wr_idx   = sp_q[IDX_W-1:0];
    assign rd_idx   = wr_idx - IDX_W'(1);
    assign full     = (sp_q == SP_W'(DEPTH));
    assign empty    = (sp_q == '0);
    assign top_data = mem_q[rd_idx];

    always_comb begin
        mem_d = mem_q;
        sp_d  = sp_q;
        if (push && !full) begin
            mem_d[wr_idx] = push_data;
            sp_d          = sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q  <= '0;
            mem_q <= '0;
        end else begin
            sp_q  <= sp_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute program-counter sequencer with jumps, conditional branches and a call/return stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            instr_valid,
    input  logic [3:0]      opcode,
    input  logic [PC_W-1:0] target,
    input  logic            cond_flag,
    output logic [PC_W-1:0] pc,
    output logic            fetch_req,
    output logic            halted,
    output logic            stack_err
);
    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] tgt_q, tgt_d;
    logic [3:0]      op_q, op_d;
    logic            cond_q, cond_d;
    logic            err_q, err_d;
    logic            push, pop;
    logic            stk_full, stk_empty;
    logic [PC_W-1:0] stk_top;
    logic [PC_W-1:0] pc_inc;

    assign pc_inc = pc_q + PC_W'(1);

    pc_return_stack #(.W(PC_W), .DEPTH(STACK_DEPTH)) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        op_d    = op_q;
        cond_d  = cond_q;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_FETCH;
            S_FETCH: begin
                if (instr_valid) begin
                    op_d    = opcode;
                    tgt_d   = target;
                    cond_d  = cond_flag;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op_q)
                    OP_JMP: pc_d = tgt_q;
                    OP_BRZ: pc_d = cond_q ? tgt_q : pc_inc;
                    OP_CALL: begin
                        if (stk_full) begin
                            err_d   = 1'b1;
                            state_d = S_HALT;
                        end else begin
                            push = 1'b1;
                            pc_d = tgt_q;
                        end
                    end
                    OP_RET: begin
                        if (stk_empty) begin
                            err_d   = 1'b1;
                            state_d = S_HALT;
                        end else begin
                            pop  = 1'b1;
                            pc_d = stk_top;
                        end
                    end
                    OP_HALT: state_d = S_HALT;
                    // NOP and every unassigned code just advance
                    default: pc_d = pc_inc;
                endcase
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            tgt_q   <= '0;
            op_q    <= OP_NOP;
            cond_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            op_q    <= op_d;
            cond_q  <= cond_d;
            err_q   <= err_d;
        end
    end

    assign pc        = pc_q;
    assign fetch_req = (state_q == S_FETCH);
    assign halted    = (state_q == S_HALT);
    assign stack_err = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and random stimulus checked every cycle against a behavioural sequencer model.
module tb_pc_sequencer;
    localparam int PC_W  = 8;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            instr_valid = 1'b0;
    logic [3:0]      opcode = 4'd0;
    logic [PC_W-1:0] target = '0;
    logic            cond_flag = 1'b0;
    logic [PC_W-1:0] pc;
    logic            fetch_req, halted, stack_err;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    pc_sequencer #(.PC_W(PC_W), .STACK_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .target      (target),
        .cond_flag   (cond_flag),
        .pc          (pc),
        .fetch_req   (fetch_req),
        .halted      (halted),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase 0 waiting for start, 1 waiting for an instruction,
    // 2 instruction captured and about to retire, 3 stopped.
    int              m_phase = 0;
    logic [PC_W-1:0] m_pc = '0;
    logic [PC_W-1:0] m_stk[$];
    bit              m_err = 0;
    logic [3:0]      m_op;
    logic [PC_W-1:0] m_tgt;
    bit              m_cond;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_pc = '0; m_err = 0; m_stk.delete();
        end else if (m_phase == 0) begin
            if (start) m_phase = 1;
        end else if (m_phase == 1) begin
            if (instr_valid) begin
                m_op = opcode; m_tgt = target; m_cond = cond_flag; m_phase = 2;
            end
        end else if (m_phase == 2) begin
            m_phase = 1;
            if (m_op == 4'd1) m_pc = m_tgt;
            else if (m_op == 4'd2) m_pc = m_cond ? m_tgt : m_pc + 8'd1;
            else if (m_op == 4'd3) begin
                if (m_stk.size() >= DEPTH) begin m_err = 1; m_phase = 3; end
                else begin m_stk.push_back(m_pc + 8'd1); m_pc = m_tgt; end
            end else if (m_op == 4'd4) begin
                if (m_stk.size() == 0) begin m_err = 1; m_phase = 3; end
                else m_pc = m_stk.pop_back();
            end else if (m_op == 4'd5) m_phase = 3;
            else m_pc = m_pc + 8'd1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pc", int'(pc), int'(m_pc));
            chk("fetch_req", int'(fetch_req), int'(m_phase == 1));
            chk("halted", int'(halted), int'(m_phase == 3));
            chk("stack_err", int'(stack_err), int'(m_err));
        end
    end

    // Pins both the DUT and the model to a hand-computed pc
    task automatic lit_pc(input string name, input logic [PC_W-1:0] exp);
        chk({name, "_dut"}, int'(pc), int'(exp));
        chk({name, "_model"}, int'(m_pc), int'(exp));
    endtask

    task automatic do_instr(input logic [3:0] op, input logic [PC_W-1:0] tgt,
                            input logic c, input int hold);
        int n = 0;
        while (!fetch_req && n < 20) begin @(negedge clk); n++; end
        if (!fetch_req) begin
            checks++; errors++;
            $display("FAIL fetch_timeout: fetch_req stayed 0, required 1");
            return;
        end
        repeat (hold) @(negedge clk);
        instr_valid = 1'b1; opcode = op; target = tgt; cond_flag = c;
        @(negedge clk);
        // stray instruction presented during execute must be ignored
        instr_valid = 1'b1; opcode = 4'($urandom); target = 8'($urandom); cond_flag = 1'($urandom);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic do_reset_start();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic logic [3:0] pick_op();
        int r = $urandom_range(0, 99);
        if (r < 20) return 4'd0;
        if (r < 35) return 4'd1;
        if (r < 50) return 4'd2;
        if (r < 68) return 4'd3;
        if (r < 86) return 4'd4;
        if (r < 89) return 4'd5;
        return 4'($urandom_range(6, 15));
    endfunction

    initial begin
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1;
        lit_pc("reset_pc", 8'h00);
        chk("reset_fetch", int'(fetch_req), 0);
        chk("reset_halted", int'(halted), 0);
        chk("reset_err", int'(stack_err), 0);

        reset = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_fetch", int'(fetch_req), 1);
        for (int i = 1; i <= 4; i++) begin
            do_instr(4'd0, 8'h00, 1'b0, i - 1);
            lit_pc("nop_seq", 8'(i));
        end

        do_instr(4'd1, 8'hFE, 1'b0, 0); lit_pc("jmp_fe", 8'hFE);
        do_instr(4'd0, 8'h00, 1'b0, 0); lit_pc("nop_ff", 8'hFF);
        do_instr(4'd0, 8'h00, 1'b0, 0); lit_pc("nop_wrap", 8'h00);

        do_instr(4'd1, 8'h05, 1'b0, 0);
        do_instr(4'd2, 8'h40, 1'b0, 1); lit_pc("brz_nt", 8'h06);
        do_instr(4'd2, 8'h40, 1'b1, 0); lit_pc("brz_t", 8'h40);
        do_instr(4'd9, 8'h77, 1'b1, 0); lit_pc("undef_nop", 8'h41);

        do_instr(4'd1, 8'h03, 1'b0, 0);
        do_instr(4'd3, 8'h10, 1'b0, 0); lit_pc("call", 8'h10);
        do_instr(4'd0, 8'h00, 1'b0, 0); lit_pc("call_nop", 8'h11);
        do_instr(4'd4, 8'h99, 1'b0, 0); lit_pc("ret", 8'h04);

        for (int i = 0; i < 4; i++) do_instr(4'd3, 8'(8'h20 + i), 1'b0, 0);
        lit_pc("nest4", 8'h23);
        do_instr(4'd3, 8'h30, 1'b0, 0);
        lit_pc("overflow_pc", 8'h23);
        chk("overflow_err", int'(stack_err), 1);
        chk("overflow_halt", int'(halted), 1);

        do_reset_start();
        do_instr(4'd4, 8'h00, 1'b0, 0);
        chk("underflow_err", int'(stack_err), 1);
        chk("underflow_halt", int'(halted), 1);
        start = 1'b1; instr_valid = 1'b1; opcode = 4'd1; target = 8'h55;
        repeat (4) @(negedge clk);
        start = 1'b0; instr_valid = 1'b0;
        chk("halt_sticky", int'(halted), 1);
        lit_pc("halt_pc", 8'h00);

        do_reset_start();
        do_instr(4'd3, 8'h55, 1'b0, 0);
        while (!fetch_req) @(negedge clk);
        instr_valid = 1'b1; opcode = 4'd3; target = 8'h66;
        @(negedge clk);
        instr_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        lit_pc("rst_exec_pc", 8'h00);
        chk("rst_exec_err", int'(stack_err), 0);
        chk("rst_exec_halt", int'(halted), 0);
        @(negedge clk);
        chk("rst_exec_idle", int'(fetch_req), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        do_instr(4'd4, 8'h00, 1'b0, 0);
        chk("rst_stack_empty", int'(stack_err), 1);

        for (int cyc = 0; cyc < 6000; cyc++) begin
            reset       = ($urandom_range(0, 79) == 0);
            start       = ($urandom_range(0, 3) == 0);
            instr_valid = ($urandom_range(0, 2) != 0);
            opcode      = pick_op();
            target      = 8'($urandom);
            cond_flag   = 1'($urandom);
            @(negedge clk);
        end
        reset = 1'b0; start = 1'b0; instr_valid = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
